// File: rtl/rope_collision_controller_pkg.sv
// Shared types and constants for the rope collision controller.
// Holds the grab FSM states, the default rope count and the screen edge limits.
package rope_collision_controller_pkg;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        HOLDING  = 2'd1,
        COOLDOWN = 2'd2
    } rope_state_e;

    localparam int          ROPES_DEFAULT       = 6;
    localparam logic [10:0] LEFT_LIMIT_DEFAULT  = 11'd8;
    localparam logic [10:0] RIGHT_LIMIT_DEFAULT = 11'd631;

    // Bits needed to hold a frame counter that counts down from max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rope_edge_tracker.sv
// Per-rope screen-edge tracker: accumulates edge hits over a frame and emits a
// one-cycle direction toggle after the frame boundary, then holds off for a few frames.
module rope_edge_tracker
    import rope_collision_controller_pkg::*;
#(
    parameter int TOGGLE_HOLDOFF = 3
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sof_i,
    input  logic edge_i,
    output logic toggle_o
);

    localparam int HW = cnt_width(TOGGLE_HOLDOFF);

    logic          edge_acc_q, edge_acc_d;
    logic [HW-1:0] holdoff_q, holdoff_d;
    logic          toggle_q, toggle_d;

    // The accumulator value at the boundary is the frame's latched edge result;
    // an edge in the boundary cycle itself starts the new frame.
    always_comb begin
        edge_acc_d = edge_acc_q | edge_i;
        holdoff_d  = holdoff_q;
        toggle_d   = 1'b0;
        if (sof_i) begin
            edge_acc_d = edge_i;
            if (holdoff_q != '0) begin
                holdoff_d = holdoff_q - HW'(1);
            end else if (edge_acc_q) begin
                toggle_d  = 1'b1;
                holdoff_d = HW'(TOGGLE_HOLDOFF);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            edge_acc_q <= 1'b0;
            holdoff_q  <= '0;
            toggle_q   <= 1'b0;
        end else begin
            edge_acc_q <= edge_acc_d;
            holdoff_q  <= holdoff_d;
            toggle_q   <= toggle_d;
        end
    end

    assign toggle_o = toggle_q;

endmodule

// File: rtl/rope_collision_controller.sv
// Monkey/rope collision controller: accumulates per-frame overlaps, runs the
// FREE/HOLDING/COOLDOWN grab FSM at each frame boundary and drives rope direction toggles.
module rope_collision_controller
    import rope_collision_controller_pkg::*;
#(
    parameter int          ROPES           = ROPES_DEFAULT,
    parameter logic [10:0] LEFT_LIMIT      = LEFT_LIMIT_DEFAULT,
    parameter logic [10:0] RIGHT_LIMIT     = RIGHT_LIMIT_DEFAULT,
    parameter int          TOGGLE_HOLDOFF  = 3,
    parameter int          COOLDOWN_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startOfFrame,
    input  logic [10:0]           pixelX,
    input  logic [10:0]           pixelY,
    input  logic [ROPES-1:0]      ropeDR,
    input  logic                  monkeyDR,
    input  logic [ROPES-1:0][31:0] SIGNED_SPEEDS,
    input  logic                  jumpReq,
    output logic [ROPES-1:0]      dirToggle,
    output logic [ROPES-1:0]      monkeyCollision,
    output logic                  grabbing,
    output logic [2:0]            grabbedIdx,
    output logic [31:0]           monkeySpeed,
    output rope_state_e           dbg_state
);

    localparam int CW = cnt_width(COOLDOWN_FRAMES);

    logic unused_pixel_y;
    assign unused_pixel_y = ^pixelY;

    logic at_edge;
    assign at_edge = (pixelX <= LEFT_LIMIT) || (pixelX >= RIGHT_LIMIT);

    for (genvar g = 0; g < ROPES; g++) begin : g_edge
        rope_edge_tracker #(
            .TOGGLE_HOLDOFF(TOGGLE_HOLDOFF)
        ) u_edge (
            .clk_i   (clk),
            .reset_i (reset),
            .sof_i   (startOfFrame),
            .edge_i  (ropeDR[g] & at_edge),
            .toggle_o(dirToggle[g])
        );
    end

    rope_state_e      state_q, state_d;
    logic [ROPES-1:0] hit_now;
    logic [ROPES-1:0] hit_acc_q, hit_acc_d;
    logic [2:0]       idx_q, idx_d;
    logic             miss_q, miss_d;
    logic [CW-1:0]    cool_q, cool_d;
    logic [ROPES-1:0] coll_q, coll_d;
    logic             grab_q, grab_d;
    logic [31:0]      speed_q, speed_d;
    logic [2:0]       low_idx;
    logic             held_hit;

    assign hit_now = ropeDR & {ROPES{monkeyDR}};

    always_comb begin
        low_idx  = '0;
        held_hit = 1'b0;
        for (int i = ROPES - 1; i >= 0; i--) begin
            if (hit_acc_q[i]) low_idx = 3'(i);
        end
        for (int i = 0; i < ROPES; i++) begin
            if (idx_q == 3'(i)) held_hit = hit_acc_q[i];
        end
    end

    // The FSM steps only on the boundary cycle, consuming the just-ended frame's hits.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        miss_d    = miss_q;
        cool_d    = cool_q;
        coll_d    = coll_q;
        grab_d    = grab_q;
        speed_d   = speed_q;
        hit_acc_d = hit_acc_q | hit_now;
        if (startOfFrame) begin
            hit_acc_d = hit_now;
            case (state_q)
                FREE: begin
                    if (|hit_acc_q) begin
                        state_d = HOLDING;
                        idx_d   = low_idx;
                        miss_d  = 1'b0;
                    end
                end
                HOLDING: begin
                    if (jumpReq || (!held_hit && miss_q)) begin
                        state_d = COOLDOWN;
                        cool_d  = CW'(COOLDOWN_FRAMES);
                        miss_d  = 1'b0;
                    end else begin
                        miss_d = !held_hit;
                    end
                end
                COOLDOWN: begin
                    if (cool_q <= CW'(1)) begin
                        state_d = FREE;
                        cool_d  = '0;
                    end else begin
                        cool_d = cool_q - CW'(1);
                    end
                end
                default: state_d = FREE;
            endcase
            grab_d  = (state_d == HOLDING);
            coll_d  = '0;
            speed_d = '0;
            if (state_d == HOLDING) begin
                for (int i = 0; i < ROPES; i++) begin
                    if (idx_d == 3'(i)) begin
                        coll_d[i] = 1'b1;
                        speed_d   = SIGNED_SPEEDS[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FREE;
            hit_acc_q <= '0;
            idx_q     <= '0;
            miss_q    <= 1'b0;
            cool_q    <= '0;
            coll_q    <= '0;
            grab_q    <= 1'b0;
            speed_q   <= '0;
        end else begin
            state_q   <= state_d;
            hit_acc_q <= hit_acc_d;
            idx_q     <= idx_d;
            miss_q    <= miss_d;
            cool_q    <= cool_d;
            coll_q    <= coll_d;
            grab_q    <= grab_d;
            speed_q   <= speed_d;
        end
    end

    assign monkeyCollision = coll_q;
    assign grabbing        = grab_q;
    assign grabbedIdx      = idx_q;
    assign monkeySpeed     = speed_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_rope_collision_controller.sv
// Bench for rope_collision_controller: frame-level behavioural model checked every
// cycle, directed scenarios with literal expectations, then randomized frames.
module tb_rope_collision_controller;
    import rope_collision_controller_pkg::*;

    localparam int ROPES = 6;
    localparam int HOLD  = 3;
    localparam int COOL  = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  startOfFrame;
    logic [10:0]           pixelX;
    logic [10:0]           pixelY;
    logic [ROPES-1:0]      ropeDR;
    logic                  monkeyDR;
    logic [ROPES-1:0][31:0] SIGNED_SPEEDS;
    logic                  jumpReq;
    logic [ROPES-1:0]      dirToggle;
    logic [ROPES-1:0]      monkeyCollision;
    logic                  grabbing;
    logic [2:0]            grabbedIdx;
    logic [31:0]           monkeySpeed;
    rope_state_e           dbg_state;

    rope_collision_controller #(
        .ROPES(ROPES), .LEFT_LIMIT(11'd8), .RIGHT_LIMIT(11'd631),
        .TOGGLE_HOLDOFF(HOLD), .COOLDOWN_FRAMES(COOL)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .ropeDR(ropeDR), .monkeyDR(monkeyDR),
        .SIGNED_SPEEDS(SIGNED_SPEEDS), .jumpReq(jumpReq),
        .dirToggle(dirToggle), .monkeyCollision(monkeyCollision),
        .grabbing(grabbing), .grabbedIdx(grabbedIdx), .monkeySpeed(monkeySpeed),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Frame-level model state: events of the open frame, frame number of the
    // last toggle per rope, frame number of the last release.
    logic [ROPES-1:0] ev_hit, ev_edge;
    int               frame_no;
    int               last_tog[ROPES];
    int               release_f;
    int               misses;
    bit               holding;
    int               held;
    logic [ROPES-1:0] exp_tog, exp_coll;
    logic             exp_grab;
    logic [2:0]       exp_idx;
    logic [31:0]      exp_speed;
    rope_state_e      exp_state;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        ev_hit = '0; ev_edge = '0; frame_no = 0; release_f = -1000;
        misses = 0; holding = 1'b0; held = 0;
        for (int i = 0; i < ROPES; i++) last_tog[i] = -1000;
        exp_tog = '0; exp_coll = '0; exp_grab = 1'b0; exp_idx = '0;
        exp_speed = '0; exp_state = FREE;
    endtask

    // Applies the inputs sampled at the edge that just occurred.
    task automatic model_step();
        logic [ROPES-1:0] ch, ce;
        ch = monkeyDR ? ropeDR : '0;
        ce = (pixelX <= 11'd8 || pixelX >= 11'd631) ? ropeDR : '0;
        exp_tog = '0;
        if (reset) begin
            model_reset();
        end else if (startOfFrame) begin
            frame_no++;
            for (int i = 0; i < ROPES; i++) begin
                if (ev_edge[i] && (frame_no - last_tog[i] > HOLD)) begin
                    exp_tog[i] = 1'b1;
                    last_tog[i] = frame_no;
                end
            end
            if (!holding) begin
                if (frame_no > release_f + COOL && ev_hit != '0) begin
                    holding = 1'b1; misses = 0;
                    for (int i = ROPES - 1; i >= 0; i--) if (ev_hit[i]) held = i;
                end
            end else if (jumpReq) begin
                holding = 1'b0; release_f = frame_no;
            end else if (!ev_hit[held]) begin
                misses++;
                if (misses >= 2) begin holding = 1'b0; release_f = frame_no; end
            end else begin
                misses = 0;
            end
            exp_grab  = holding;
            exp_idx   = 3'(held);
            exp_coll  = holding ? ROPES'(1 << held) : '0;
            exp_speed = holding ? SIGNED_SPEEDS[held] : 32'd0;
            exp_state = holding ? HOLDING : ((frame_no < release_f + COOL) ? COOLDOWN : FREE);
            ev_hit = ch; ev_edge = ce;
        end else begin
            ev_hit  = ev_hit | ch;
            ev_edge = ev_edge | ce;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("dirToggle", 32'(dirToggle), 32'(exp_tog));
            check("monkeyCollision", 32'(monkeyCollision), 32'(exp_coll));
            check("grabbing", 32'(grabbing), 32'(exp_grab));
            check("grabbedIdx", 32'(grabbedIdx), 32'(exp_idx));
            check("monkeySpeed", monkeySpeed, exp_speed);
            check("state", 32'(dbg_state), 32'(exp_state));
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        reset = 1'b0; startOfFrame = 1'b0; ropeDR = '0; monkeyDR = 1'b0;
        pixelX = 11'd320; jumpReq = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic frame_end();
        startOfFrame = 1'b1;
        cycle();
        startOfFrame = 1'b0;
    endtask

    task automatic overlap(input logic [ROPES-1:0] mask);
        ropeDR = mask; monkeyDR = 1'b1; pixelX = 11'd320;
        cycle();
        ropeDR = '0; monkeyDR = 1'b0;
    endtask

    task automatic edge_px(input logic [ROPES-1:0] mask);
        ropeDR = mask; monkeyDR = 1'b0; pixelX = 11'd5;
        cycle();
        ropeDR = '0; pixelX = 11'd320;
    endtask

    initial begin
        set_idle();
        pixelY = 11'd0;
        for (int i = 0; i < ROPES; i++) SIGNED_SPEEDS[i] = 32'(i * 11 + 7);
        SIGNED_SPEEDS[1] = -32'sd40;
        SIGNED_SPEEDS[3] = 32'd1234;
        SIGNED_SPEEDS[4] = 32'd77;
        SIGNED_SPEEDS[0] = 32'd7;
        reset = 1'b1;
        cycle();
        chk_en = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_grabbing", 32'(grabbing), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(FREE));

        // Two ropes overlapped in one frame: lowest index wins.
        idle(2); overlap(6'b010010); idle(3); frame_end();
        check("grab_idx", 32'(grabbedIdx), 32'd1);
        check("grab_coll", 32'(monkeyCollision), 32'b000010);
        check("grab_speed", monkeySpeed, 32'hFFFF_FFD8);
        check("grab_flag", 32'(grabbing), 32'd1);

        // Lose contact for two frames, then cooldown with rope 3 overlapping.
        idle(3); frame_end();
        idle(3); frame_end();
        check("lost1_cool", 32'(dbg_state), 32'(COOLDOWN));
        for (int k = 1; k <= 8; k++) begin
            overlap(6'b001000); idle(2); frame_end();
            check("cool_nograb", 32'(grabbing), 32'd0);
        end
        overlap(6'b001000); idle(2); frame_end();
        check("grab3_flag", 32'(grabbing), 32'd1);
        check("grab3_speed", monkeySpeed, 32'd1234);

        // Jump while still overlapping rope 3: release wins.
        overlap(6'b001000); idle(2);
        jumpReq = 1'b1; frame_end(); jumpReq = 1'b0;
        check("jump_grab", 32'(grabbing), 32'd0);
        check("jump_speed", monkeySpeed, 32'd0);
        check("jump_idx_kept", 32'(grabbedIdx), 32'd3);
        for (int k = 1; k <= 8; k++) begin
            overlap(6'b001001); idle(2); frame_end();
            check("jump_cool_nograb", 32'(grabbing), 32'd0);
        end
        overlap(6'b001001); idle(2); frame_end();
        check("grab0_idx", 32'(grabbedIdx), 32'd0);
        check("grab0_flag", 32'(grabbing), 32'd1);

        // Rope 0: one missed frame keeps the grab, two release it.
        idle(3); frame_end();
        check("miss1_hold", 32'(grabbing), 32'd1);
        idle(3); frame_end();
        check("miss2_grab", 32'(grabbing), 32'd0);
        check("miss2_state", 32'(dbg_state), 32'(COOLDOWN));

        // Rope 2 edge pixels: one toggle, then three suppressed frames.
        edge_px(6'b000100); idle(2); frame_end();
        check("tog_pulse", 32'(dirToggle), 32'b000100);
        cycle();
        check("tog_one_cycle", 32'(dirToggle), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            edge_px(6'b000100); idle(2); frame_end();
            check("tog_holdoff", 32'(dirToggle), 32'd0);
        end
        edge_px(6'b000100); idle(2); frame_end();
        check("tog_again", 32'(dirToggle), 32'b000100);

        for (int k = 0; k < 5; k++) begin idle(3); frame_end(); end
        check("free_again", 32'(dbg_state), 32'(FREE));

        // Overlap in the boundary cycle belongs to the next frame.
        startOfFrame = 1'b1; ropeDR = 6'b100000; monkeyDR = 1'b1;
        cycle();
        set_idle();
        check("sof_ovl_late", 32'(grabbing), 32'd0);
        idle(3); frame_end();
        check("sof_ovl_grab", 32'(grabbing), 32'd1);
        check("sof_ovl_idx", 32'(grabbedIdx), 32'd5);

        // Reset while holding, with pending edge and overlap data.
        edge_px(6'b010000); overlap(6'b000100);
        reset = 1'b1; cycle(); reset = 1'b0;
        check("rst_hold_grab", 32'(grabbing), 32'd0);
        check("rst_hold_coll", 32'(monkeyCollision), 32'd0);
        check("rst_hold_speed", monkeySpeed, 32'd0);
        check("rst_hold_idx", 32'(grabbedIdx), 32'd0);
        check("rst_hold_state", 32'(dbg_state), 32'(FREE));
        idle(2); frame_end();
        check("rst_no_tog", 32'(dirToggle), 32'd0);
        check("rst_no_grab", 32'(grabbing), 32'd0);

        // Randomized frames.
        for (int f = 0; f < 400; f++) begin
            int len;
            len = $urandom_range(3, 12);
            for (int i = 0; i < ROPES; i++) SIGNED_SPEEDS[i] = $urandom;
            for (int c = 0; c < len; c++) begin
                ropeDR   = ROPES'($urandom) & ROPES'($urandom);
                monkeyDR = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 2))
                    0:       pixelX = 11'($urandom_range(0, 12));
                    1:       pixelX = 11'($urandom_range(626, 639));
                    default: pixelX = 11'($urandom_range(0, 639));
                endcase
                pixelY       = 11'($urandom_range(0, 479));
                jumpReq      = ($urandom_range(0, 7) == 0);
                startOfFrame = (c == len - 1);
                reset        = ($urandom_range(0, 299) == 0);
                cycle();
            end
        end
        set_idle();
        idle(2);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rope_collision_controller.md
ROPE_COLLISION_CONTROLLER -- requirements
Module: rope_collision_controller

Interface
REQ-001 Parameter ROPES, default 6: number of rope instances served.
REQ-002 Parameter LEFT_LIMIT, default 11'd8: pixelX at or below which a rope pixel counts as touching the left edge.
REQ-003 Parameter RIGHT_LIMIT, default 11'd631: pixelX at or above which a rope pixel counts as touching the right edge.
REQ-004 Parameter TOGGLE_HOLDOFF, default 3: frames a rope's edge detection stays suppressed after a toggle.
REQ-005 Parameter COOLDOWN_FRAMES, default 8: frames after a release during which no grab is accepted.
REQ-006 clk  in  1  system clock, the single clock domain.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 startOfFrame  in  1  one-cycle pulse marking the frame boundary.
REQ-009 pixelX  in  11  current VGA column.
REQ-010 pixelY  in  11  current VGA row; not used by the logic, kept for port uniformity.
REQ-011 ropeDR  in  ROPES  per-rope drawing request.
REQ-012 monkeyDR  in  1  monkey drawing request.
REQ-013 SIGNED_SPEEDS  in  ROPES x 32  per-rope signed X speed.
REQ-014 jumpReq  in  1  level-sensitive player request to release the rope.
REQ-015 dirToggle  out  ROPES  one-cycle pulse per rope that reverses that rope's direction.
REQ-016 monkeyCollision  out  ROPES  one-hot flag for the held rope; all zero when no rope is held.
REQ-017 grabbing  out  1  high while state is HOLDING.
REQ-018 grabbedIdx  out  3  index of the held rope.
REQ-019 monkeySpeed  out  32  signed speed of the held rope; 0 when no rope is held.

Function
REQ-020 Each cycle, hitAcc[i] SHALL be set when ropeDR[i] and monkeyDR are both high.
REQ-021 Each cycle, edgeAcc[i] SHALL be set when ropeDR[i] is high and pixelX <= LEFT_LIMIT or pixelX >= RIGHT_LIMIT.
REQ-022 On startOfFrame, the accumulators SHALL be copied into hitLat/edgeLat and then cleared.
- A hit or edge event in the same cycle as startOfFrame belongs to the new frame.
REQ-023 In the cycle after startOfFrame, dirToggle[i] SHALL pulse for exactly one cycle when edgeLat[i]=1 and holdoff[i]=0.
- holdoff[i] is then loaded with TOGGLE_HOLDOFF.
REQ-024 Each nonzero holdoff[i] SHALL decrement once per startOfFrame.
- While it is nonzero, edgeLat[i] is ignored.
REQ-025 The FSM SHALL have three states: FREE, HOLDING, COOLDOWN.
- The FSM evaluates only in the cycle after startOfFrame, using latched values and jumpReq sampled at startOfFrame.
REQ-026 FREE -> HOLDING when any hitLat bit is set.
- grabbedIdx = lowest set index.
- Multiple simultaneous hits resolve to the lowest index.
REQ-027 In HOLDING, monkeySpeed SHALL be re-sampled from SIGNED_SPEEDS[grabbedIdx] once per frame.
- monkeyCollision = one-hot(grabbedIdx).
REQ-028 HOLDING -> COOLDOWN when the sampled jumpReq=1.
- Also when hitLat[grabbedIdx]=0 for 2 consecutive frames (lost contact).
- jumpReq has priority when both conditions occur in the same frame.
REQ-029 On entering COOLDOWN, the counter SHALL load COOLDOWN_FRAMES and decrement per frame.
- COOLDOWN -> FREE in the frame the counter reaches 0.
- Hits during COOLDOWN are ignored.
REQ-030 Outside HOLDING: monkeyCollision=0, monkeySpeed=0, grabbing=0; grabbedIdx keeps its last value.
REQ-031 All outputs SHALL be registered; the FSM responds with one cycle of latency from startOfFrame.

Reset
REQ-032 reset SHALL force, on the next clk edge:
- state FREE;
- all accumulators, latches, holdoff and cooldown counters to 0;
- every output to 0.
REQ-033 reset SHALL take priority over startOfFrame in the same cycle.
- An assertion mid-frame or mid-HOLDING discards all partial frame data.

Structure
REQ-034 A shared package SHALL hold:
- the state enum (FREE, HOLDING, COOLDOWN);
- the ROPES default;
- the screen limit constants.
REQ-035 Per-rope edge detection and holdoff logic SHALL be one sub-module, rope_edge_tracker, instantiated ROPES times by a generate loop.

Verification
REQ-036 Rope 2 pixels with pixelX=5 in frame N -> dirToggle[2] pulses once in the cycle after startOfFrame N+1.
- No further pulse on rope 2 for the next 3 frames, even if its edge pixels persist.
REQ-037 monkeyDR overlaps ropeDR[1] and ropeDR[4] in the same frame -> grabbedIdx=1, monkeyCollision=6'b000010.
- monkeySpeed equals SIGNED_SPEEDS[1], e.g. -40.
REQ-038 HOLDING rope 3, jumpReq=1 at startOfFrame -> grabbing=0 and monkeySpeed=0 one cycle later.
- An overlap with rope 3 within the next 8 frames produces no grab; a grab is accepted in frame 9.
REQ-039 HOLDING rope 0, no overlap for 1 frame -> still HOLDING.
- No overlap for 2 frames -> COOLDOWN.
REQ-040 Overlap coincident with the startOfFrame cycle -> counted in the following frame, not the ending one.
REQ-041 reset asserted for one cycle while HOLDING -> all outputs 0 on the next edge, state FREE, no dirToggle pulse at the next frame.
